// File: rtl/uart_rx_data_sampler.sv
// UART RX data sampler: per-bit edge counter, bit counter and 3-point majority vote.
// Define UART_RX_SAMPLER_SYNC_EN to pass RX_IN through a two-flop synchronizer first.
module uart_rx_data_sampler #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      sample_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      sampled_data,
    output logic                      sampled,
    output logic                      bit_done
);

    localparam logic [PRESCALE_WIDTH-1:0] CntOne = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    logic                      w_rx;
    logic                      w_run;
    logic                      w_wrap;
    logic [PRESCALE_WIDTH-1:0] w_half;
    logic [PRESCALE_WIDTH-1:0] w_last;
    logic [PRESCALE_WIDTH-1:0] w_pt0;
    logic [PRESCALE_WIDTH-1:0] w_pt1;
    logic [PRESCALE_WIDTH-1:0] w_pt2;

    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [PRESCALE_WIDTH-1:0] w_edge_cnt_nxt;
    logic [3:0]                r_bit_cnt;
    logic [3:0]                w_bit_cnt_nxt;
    logic                      r_s0;
    logic                      r_s1;
    logic                      r_s2;
    logic                      w_s0_nxt;
    logic                      w_s1_nxt;
    logic                      w_s2_nxt;
    logic                      r_sampled_data;
    logic                      w_sampled_data_nxt;
    logic                      r_sampled;
    logic                      w_sampled_nxt;
    logic                      r_bit_done;
    logic                      w_bit_done_nxt;
    logic                      r_blocked;

`ifdef UART_RX_SAMPLER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    assign w_half = prescale >> 1;
    assign w_last = prescale - CntOne;
    assign w_pt0  = w_half - CntOne;
    assign w_pt1  = w_half;
    assign w_pt2  = w_half + CntOne;

    // After reset the counters stay idle until sample_en has been seen low once.
    assign w_run  = sample_en & ~r_blocked;
    // '>=' so a shrinking prescale wraps immediately and illegal values never lock up.
    assign w_wrap = w_run & (r_edge_cnt >= w_last);

    always_comb begin
        w_edge_cnt_nxt     = '0;
        w_bit_cnt_nxt      = '0;
        w_s0_nxt           = r_s0;
        w_s1_nxt           = r_s1;
        w_s2_nxt           = r_s2;
        w_sampled_data_nxt = r_sampled_data;
        w_sampled_nxt      = 1'b0;
        w_bit_done_nxt     = 1'b0;

        if (w_run) begin
            if (w_wrap) begin
                w_edge_cnt_nxt = '0;
                w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
                w_bit_done_nxt = 1'b1;
            end else begin
                w_edge_cnt_nxt = r_edge_cnt + CntOne;
                w_bit_cnt_nxt  = r_bit_cnt;
            end

            if (r_edge_cnt == w_pt0) begin
                w_s0_nxt = w_rx;
            end
            if (r_edge_cnt == w_pt1) begin
                w_s1_nxt = w_rx;
            end
            // Vote uses the live third sample so the strobe lands at P/2+2.
            if (r_edge_cnt == w_pt2) begin
                w_s2_nxt           = w_rx;
                w_sampled_nxt      = 1'b1;
                w_sampled_data_nxt = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_edge_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_s2           <= 1'b1;
            r_sampled_data <= 1'b1;
            r_sampled      <= 1'b0;
            r_bit_done     <= 1'b0;
        end else begin
            r_edge_cnt     <= w_edge_cnt_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_s0           <= w_s0_nxt;
            r_s1           <= w_s1_nxt;
            r_s2           <= w_s2_nxt;
            r_sampled_data <= w_sampled_data_nxt;
            r_sampled      <= w_sampled_nxt;
            r_bit_done     <= w_bit_done_nxt;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_blocked <= 1'b1;
        end else if (!sample_en) begin
            r_blocked <= 1'b0;
        end
    end

    assign edge_cnt     = r_edge_cnt;
    assign bit_cnt      = r_bit_cnt;
    assign sampled_data = r_sampled_data;
    assign sampled      = r_sampled;
    assign bit_done     = r_bit_done;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed bench for uart_rx_data_sampler; expectations adjust for UART_RX_SAMPLER_SYNC_EN.
`timescale 1ns/1ps
module tb_uart_rx_data_sampler;

`ifdef UART_RX_SAMPLER_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_data;
    logic       sampled;
    logic       bit_done;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_sampled = 0;
    int         n_done = 0;
    int         snap_s;
    int         snap_d;
    logic       last_data = 1'b1;
    logic [7:0] deser = '0;
    logic [9:0] frame;

    uart_rx_data_sampler #(
        .PRESCALE_WIDTH(6)
    ) u_dut (
        .CLK         (clk),
        .Reset       (rst),
        .RX_IN       (rx),
        .prescale    (prescale),
        .sample_en   (en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_data(sampled_data),
        .sampled     (sampled),
        .bit_done    (bit_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; also tallies strobes and feeds a model deserializer for data bits 1..8.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sampled === 1'b1) begin
            n_sampled++;
            last_data = sampled_data;
            if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) deser = {sampled_data, deser[7:1]};
        end
        if (bit_done === 1'b1) n_done++;
    endtask

    task automatic drive_bit(input int p, input logic base, input logic [31:0] flip);
        for (int k = 0; k < p; k++) begin
            rx = base ^ flip[k];
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        en = 1'b0;
        prescale = 6'd8;
        #12;
        check_eq("rst_edge_cnt", edge_cnt, 0);
        check_eq("rst_bit_cnt", bit_cnt, 0);
        check_eq("rst_sampled_data", sampled_data, 1);
        check_eq("rst_sampled", sampled, 0);
        check_eq("rst_bit_done", bit_done, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("idle_edge_cnt", edge_cnt, 0);

        // P=8, line held low for one bit
        en = 1'b1;
        rx = 1'b0;
        check_eq("p8_start_edge", edge_cnt, 0);
        repeat (5) tick();
        check_eq("p8_no_early_strobe", sampled, 0);
        check_eq("p8_data_held", sampled_data, 1);
        tick();
        check_eq("p8_strobe_edge", edge_cnt, 6);
        check_eq("p8_strobe", sampled, 1);
        check_eq("p8_data", sampled_data, 0);
        tick();
        check_eq("p8_strobe_single", sampled, 0);
        check_eq("p8_no_early_done", bit_done, 0);
        tick();
        check_eq("p8_wrap_edge", edge_cnt, 0);
        check_eq("p8_bit_done", bit_done, 1);
        check_eq("p8_bit_cnt", bit_cnt, 1);
        en = 1'b0;
        tick();
        check_eq("dis_bit_cnt", bit_cnt, 0);
        check_eq("dis_bit_done", bit_done, 0);

        // P=16 glitch votes
        prescale = 6'd16;
        en = 1'b1;
        snap_s = n_sampled;
        snap_d = n_done;
        drive_bit(16, 1'b1, 32'h100 << Lat);
        check_eq("glitch0_in_ones", last_data, 1);
        drive_bit(16, 1'b0, 32'h100 << Lat);
        check_eq("glitch1_in_zeros", last_data, 0);
        drive_bit(16, 1'b0, 32'h300 << Lat);
        check_eq("two_of_three_ones", last_data, 1);
        check_eq("glitch_strobes", n_sampled - snap_s, 3);
        check_eq("glitch_dones", n_done - snap_d, 3);
        check_eq("glitch_bit_cnt", bit_cnt, 3);
        en = 1'b0;
        tick();

        // P=32 frame 0x1_A5_0, LSB first
        prescale = 6'd32;
        frame = 10'h34A;
        deser = '0;
        snap_s = n_sampled;
        snap_d = n_done;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("frame_bit_cnt%0d", i), bit_cnt, i);
            drive_bit(32, frame[i], 32'h0);
            check_eq($sformatf("frame_data%0d", i), last_data, frame[i]);
        end
        check_eq("frame_strobes", n_sampled - snap_s, 10);
        check_eq("frame_dones", n_done - snap_d, 10);
        check_eq("frame_byte", deser, 8'hA5);
        en = 1'b0;
        tick();

        // sample_en dropped at edge P/2+1 suppresses the strobe
        prescale = 6'd8;
        en = 1'b1;
        rx = 1'b0;
        snap_s = n_sampled;
        repeat (5) tick();
        check_eq("drop5_edge", edge_cnt, 5);
        en = 1'b0;
        tick();
        check_eq("drop5_no_strobe", sampled, 0);
        check_eq("drop5_edge_clr", edge_cnt, 0);
        check_eq("drop5_bit_clr", bit_cnt, 0);
        check_eq("drop5_data_held", sampled_data, 1);
        check_eq("drop5_strobe_cnt", n_sampled - snap_s, 0);

        // sample_en dropped at edge P-1 suppresses bit_done
        en = 1'b1;
        repeat (7) tick();
        check_eq("drop7_edge", edge_cnt, 7);
        en = 1'b0;
        tick();
        check_eq("drop7_no_done", bit_done, 0);
        check_eq("drop7_bit_clr", bit_cnt, 0);

        // prescale shrinks below the current edge count
        prescale = 6'd16;
        rx = 1'b1;
        en = 1'b1;
        repeat (10) tick();
        check_eq("pchg_edge", edge_cnt, 10);
        prescale = 6'd8;
        tick();
        check_eq("pchg_wrap", edge_cnt, 0);
        check_eq("pchg_done", bit_done, 1);
        check_eq("pchg_bit_cnt", bit_cnt, 1);
        en = 1'b0;
        tick();

        // illegal prescale still wraps at P-1
        prescale = 6'd12;
        en = 1'b1;
        repeat (11) tick();
        check_eq("p12_edge", edge_cnt, 11);
        tick();
        check_eq("p12_wrap", edge_cnt, 0);
        check_eq("p12_done", bit_done, 1);
        en = 1'b0;
        tick();

        // falling edge mid-bit: synchronizer delay changes the vote
        prescale = 6'd8;
        rx = 1'b1;
        tick();
        en = 1'b1;
        snap_s = n_sampled;
        drive_bit(8, 1'b1, 32'hF0);
        check_eq("edge_latency_vote", last_data, (Lat == 2) ? 1 : 0);
        check_eq("edge_latency_strobe", n_sampled - snap_s, 1);
        en = 1'b0;
        tick();

        // asynchronous reset at bit 3
        en = 1'b1;
        drive_bit(8, 1'b0, 32'h0);
        drive_bit(8, 1'b0, 32'h0);
        drive_bit(8, 1'b0, 32'h0);
        check_eq("prerst_bit_cnt", bit_cnt, 3);
        check_eq("prerst_data", sampled_data, 0);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_edge_cnt", edge_cnt, 0);
        check_eq("arst_bit_cnt", bit_cnt, 0);
        check_eq("arst_sampled_data", sampled_data, 1);
        check_eq("arst_sampled", sampled, 0);
        check_eq("arst_bit_done", bit_done, 0);
        @(negedge clk);
        rst = 1'b0;
        snap_s = n_sampled;
        snap_d = n_done;
        repeat (12) tick();
        check_eq("postrst_no_strobe", n_sampled - snap_s, 0);
        check_eq("postrst_no_done", n_done - snap_d, 0);
        check_eq("postrst_edge_idle", edge_cnt, 0);
        en = 1'b0;
        tick();
        en = 1'b1;
        drive_bit(8, 1'b0, 32'h0);
        check_eq("restart_strobe", n_sampled - snap_s, 1);
        check_eq("restart_data", last_data, 0);
        check_eq("restart_bit_cnt", bit_cnt, 1);
        en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
